// File: rtl/init_pop.sv
// Initial-population generator: xorshift32 PRNG fills POP_BITS of population, CHUNK bits per clock.
// done rises NCHUNK edges after the start-sampling edge; start is ignored until the run completes.
module init_pop #(
    parameter int POP_BITS = 7500,
    parameter int CHUNK    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         prg_seed,
    output logic [POP_BITS-1:0] population,
    output logic                done
);

    localparam int NCHUNK = (POP_BITS + CHUNK - 1) / CHUNK;
    localparam int LAST_W = POP_BITS - (NCHUNK - 1) * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_prng;
    logic [KW-1:0] r_k;
    logic [31:0] w_next;
    logic [31:0] w_seed;
    logic        w_load;
    logic        w_step;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    assign w_next = xs(r_prng);
    // All-zero is a fixed point of xorshift, so a zero seed would yield an all-zero population.
    assign w_seed = (prg_seed == 32'd0) ? 32'h0000_0001 : prg_seed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)         w_state_nxt = S_FILL;
            S_FILL:  if (r_k == K_LAST) w_state_nxt = S_DONE;
            S_DONE:  if (!start)        w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE:  w_load = start;
            S_FILL:  w_step = 1'b1;
            S_DONE:  done   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prng <= 32'd0;
            r_k    <= '0;
        end else if (w_load) begin
            r_prng <= w_seed;
            r_k    <= '0;
        end else if (w_step) begin
            r_prng <= w_next;
            r_k    <= r_k + 1'b1;
        end
    end

    // One register per chunk; the final chunk is truncated so writes stay inside POP_BITS.
    for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
        localparam int W = (c == NCHUNK - 1) ? LAST_W : CHUNK;
        localparam logic [KW-1:0] CI = KW'(c);
        logic [W-1:0] r_chunk;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_chunk <= '0;
            end else if (w_step && (r_k == CI)) begin
                r_chunk <= w_next[W-1:0];
            end
        end

        assign population[c*CHUNK +: W] = r_chunk;
    end

endmodule

// File: tb/tb_init_pop.sv
// Directed bench for init_pop: reset, nominal/zero-seed runs, mid-run events and rerun against an xorshift32 model.
module tb_init_pop;

    localparam int POP  = 7500;
    localparam int NCH  = 235;
    localparam logic [31:0] NOM_SEED = 32'd2682981917;

    logic            clk;
    logic            reset;
    logic            start;
    logic [31:0]     prg_seed;
    logic [POP-1:0]  population;
    logic            done;

    int n_checks = 0;
    int n_fail   = 0;

    init_pop #(.POP_BITS(POP), .CHUNK(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prg_seed   (prg_seed),
        .population (population),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [POP-1:0] model_pop(input logic [31:0] seed);
        logic [POP-1:0] p;
        logic [31:0]    x;
        p = '0;
        x = (seed == 32'd0) ? 32'd1 : seed;
        for (int k = 0; k < NCH; k++) begin
            x = xs(x);
            if (k < NCH - 1) p[k*32 +: 32] = x;
            else             p[7488 +: 12] = x[11:0];
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop(input string tag, input logic [31:0] seed);
        logic [POP-1:0] e;
        e = model_pop(seed);
        for (int k = 0; k < NCH - 1; k++)
            check($sformatf("%s_c%0d", tag, k), population[k*32 +: 32], e[k*32 +: 32]);
        check($sformatf("%s_c%0d", tag, NCH - 1), {20'd0, population[7488 +: 12]}, {20'd0, e[7488 +: 12]});
    endtask

    // Starts a run from IDLE, optionally dropping start or changing the seed mid-FILL.
    task automatic run(input string tag, input logic [31:0] seed, input int drop_at, input int chg_at);
        int cnt;
        cnt      = -1;
        prg_seed = seed;
        start    = 1'b1;
        while (1) begin
            tick();
            cnt++;
            if (cnt == drop_at) start = 1'b0;
            if (cnt == chg_at)  prg_seed = seed ^ 32'hA5A5_5A5A;
            if (done || cnt >= 400) break;
        end
        check({tag, "_lat"}, 32'(cnt), 32'd235);
        check_pop(tag, seed);
    endtask

    initial begin
        int bad;
        clk      = 1'b0;
        reset    = 1'b0;
        start    = 1'b0;
        prg_seed = 32'd0;

        #2 reset = 1'b1;
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_pop",  32'(|population), 32'd0);
        start = 1'b1;
        repeat (10) tick();
        check("rst_hold_done", 32'(done), 32'd0);
        check("rst_hold_pop",  32'(|population), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        run("nom", NOM_SEED, -1, -1);
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (done !== 1'b1 || population !== model_pop(NOM_SEED)) bad++;
        end
        check("nom_stable_bad_cycles", 32'(bad), 32'd0);

        start = 1'b0;
        tick();
        check("rerun_idle_done", 32'(done), 32'd0);
        check("rerun_retained", 32'(population === model_pop(NOM_SEED)), 32'd1);
        run("seed1", 32'd1, -1, -1);

        tick();
        #2 reset = 1'b1;
        #1;
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_pop",  32'(|population), 32'd0);
        repeat (10) tick();
        check("async_hold_done", 32'(done), 32'd0);
        check("async_hold_pop",  32'(|population), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        run("zero", 32'd0, -1, -1);
        check("zero_c0_const", population[31:0], 32'h0004_2021);
        check("zero_nonzero", 32'(|population), 32'd1);
        start = 1'b0;
        tick();

        run("drop", NOM_SEED, 50, -1);
        tick();
        check("drop_idle_done", 32'(done), 32'd0);

        run("chg", NOM_SEED, -1, 80);
        start = 1'b0;
        tick();

        prg_seed = NOM_SEED;
        start    = 1'b1;
        repeat (101) tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pop",  32'(|population), 32'd0);
        start = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        check("midrst_idle_done", 32'(done), 32'd0);
        run("after_rst", NOM_SEED, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
